// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin front end sharing one APB master port among NUM_REQ requesters.
// Optional ACCESS-phase timeout is compiled in when APB_ARB_TIMEOUT_EN is defined.
module apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          PCLK,
  input  logic                          PRESET,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          busy,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic                          PWRITE,
  output logic [ADDR_WIDTH-1:0]         PADDR,
  output logic [DATA_WIDTH-1:0]         PWDATA,
  input  logic [DATA_WIDTH-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 1");
  end

  state_e                  state_q;
  logic [IDX_W-1:0]        ptr_q;
  logic [IDX_W-1:0]        gnt_idx_q;
  logic                    psel_q;
  logic                    penable_q;
  logic                    pwrite_q;
  logic [ADDR_WIDTH-1:0]   paddr_q;
  logic [DATA_WIDTH-1:0]   pwdata_q;
  logic [NUM_REQ-1:0]      rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    rsp_err_q;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0]            tmo_cnt_q;
`endif

  logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Search starts one past the last winner so every pending requester is served within NUM_REQ grants.
  logic             gnt_found;
  logic [IDX_W-1:0] gnt_idx;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int               sum;
      logic [IDX_W-1:0] cand;
      sum = int'(ptr_q) + k;
      if (sum >= NUM_REQ) begin
        sum = sum - NUM_REQ;
      end
      cand = IDX_W'(sum);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  logic               accept;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] owner_oh;

  assign accept    = (state_q == ST_IDLE) && gnt_found;
  assign gnt_oh    = NUM_REQ'(1) << gnt_idx;
  assign owner_oh  = NUM_REQ'(1) << gnt_idx_q;
  assign req_ready = accept ? gnt_oh : '0;

  // In the response cycle the FSM is already IDLE; busy only reflects a back-to-back grant there.
  assign busy = (state_q != ST_IDLE) || (accept && (rsp_valid_q != '0));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      gnt_idx_q   <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_found) begin
            ptr_q     <= gnt_idx;
            gnt_idx_q <= gnt_idx;
            pwrite_q  <= req_write[gnt_idx];
            paddr_q   <= addr_arr[gnt_idx];
            pwdata_q  <= wdata_arr[gnt_idx];
            psel_q    <= 1'b1;
            penable_q <= 1'b0;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
          tmo_cnt_q <= '0;
`endif
        end
        ST_ACCESS: begin
          if (PREADY) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= owner_oh;
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
            state_q     <= ST_IDLE;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (tmo_cnt_q == TMO_LAST) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= owner_oh;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
          end
`endif
        end
        default: begin
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed vector table, multi-cycle corner sequences and a randomized
// run against a transfer-level reference model of the round-robin APB front end.
module tb_apb_req_arbiter;
  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic             PCLK = 1'b0;
  logic             PRESET;
  logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, PWDATA, PRDATA;
  logic             rsp_err, busy, PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0]    PADDR;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    int          id;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic adv();
    @(posedge PCLK);
    #1;
  endtask

  task automatic smp();
    @(negedge PCLK);
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] r;
    r = '0;
    if (i >= 0 && i < NR) r[i] = 1'b1;
    return r;
  endfunction

  // Winner is the first valid requester after ptr in circular order.
  function automatic int rr_pick(input int ptr, input logic [NR-1:0] v);
    logic [2*NR-1:0] dbl;
    dbl = {v, v} >> (ptr + 1);
    for (int j = 0; j < NR; j++) begin
      if (dbl[j]) return (ptr + 1 + j) % NR;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]            = 1'b1;
    req_write[i]            = wr;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
  endtask

  task automatic do_reset();
    PRESET    = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    adv();
    adv();
    PRESET = 1'b0;
  endtask

  task automatic run_xfer(input int n, input vec_t v);
    set_req(v.id, v.wr, v.addr, v.wdata);
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h0;
    smp();
    chk("v_ready_c0", 64'(req_ready), 64'(oh(v.id)));
    chk("v_busy_c0", 64'(busy), 64'(0));
    adv();
    req_valid = '0;
    req_addr[v.id*AW +: AW]  = ~v.addr;
    req_wdata[v.id*DW +: DW] = ~v.wdata;
    smp();
    chk("v_setup_psel", 64'(PSEL), 64'(1));
    chk("v_setup_penable", 64'(PENABLE), 64'(0));
    chk("v_setup_paddr", 64'(PADDR), 64'(v.addr));
    chk("v_setup_pwrite", 64'(PWRITE), 64'(v.wr));
    chk("v_setup_pwdata", 64'(PWDATA), 64'(v.wdata));
    chk("v_setup_busy", 64'(busy), 64'(1));
    adv();
    for (int w = 0; w <= v.waits; w++) begin
      PREADY  = (w == v.waits);
      PSLVERR = v.err & PREADY;
      PRDATA  = PREADY ? v.prdata : (32'h0BAD_0000 | 32'(w));
      smp();
      chk("v_access_psel", 64'(PSEL), 64'(1));
      chk("v_access_penable", 64'(PENABLE), 64'(1));
      chk("v_access_paddr", 64'(PADDR), 64'(v.addr));
      chk("v_access_rspv", 64'(rsp_valid), 64'(0));
      adv();
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = 32'h5555_AAAA;
    smp();
    chk("v_rsp_valid", 64'(rsp_valid), 64'(oh(v.id)));
    chk("v_rsp_err", 64'(rsp_err), 64'(v.exp_err));
    chk("v_rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
    chk("v_rsp_psel", 64'(PSEL), 64'(0));
    chk("v_rsp_busy", 64'(busy), 64'(0));
    $display("vec %0d: req %0d %s addr 0x%02h waits %0d -> rdata 0x%08h err %0b",
             n, v.id, v.wr ? "WR" : "RD", v.addr, v.waits, rsp_rdata, rsp_err);
    adv();
    smp();
    chk("v_after_rspv", 64'(rsp_valid), 64'(0));
    chk("v_hold_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
    chk("v_hold_err", 64'(rsp_err), 64'(v.exp_err));
    adv();
  endtask

  // Reference-model state for the randomized phase.
  bit            m_active, m_resp_now;
  int            m_age, m_g, m_rsp_g, m_ptr;
  logic          m_wr, m_exp_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_exp_rdata;

  initial begin
    int q[$];
    int exp_next, nrsp, acc, acc_g, g, n_rand;
    bit rsp_seen, aborted, in_setup, in_access, nresp;
    logic [NR-1:0] exp_ready;

    vecs[0] = '{0, 1'b1, 8'h08, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 1'b0, 32'h0,        1'b0};
    vecs[1] = '{2, 1'b0, 8'h08, 32'h11111111, 32'hDEADBEEF, 3, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[2] = '{1, 1'b1, 8'h3C, 32'hA5A5A5A5, 32'hFFFFFFFF, 0, 1'b1, 32'h0,        1'b1};
    vecs[3] = '{3, 1'b0, 8'hFF, 32'h0,        32'h12345678, 1, 1'b1, 32'h12345678, 1'b1};
    vecs[4] = '{0, 1'b0, 8'h00, 32'h0,        32'h00000000, 0, 1'b0, 32'h0,        1'b0};
    vecs[5] = '{1, 1'b0, 8'h80, 32'h0,        32'hCAFEF00D, 5, 1'b0, 32'hCAFEF00D, 1'b0};

    PRESET = 1'b1;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    smp();
    chk("rst_psel", 64'(PSEL), 64'(0));
    chk("rst_penable", 64'(PENABLE), 64'(0));
    chk("rst_pwrite", 64'(PWRITE), 64'(0));
    chk("rst_paddr", 64'(PADDR), 64'(0));
    chk("rst_pwdata", 64'(PWDATA), 64'(0));
    chk("rst_rspv", 64'(rsp_valid), 64'(0));
    chk("rst_rdata", 64'(rsp_rdata), 64'(0));
    chk("rst_err", 64'(rsp_err), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    adv();
    PRESET = 1'b0;

    for (int i = 0; i < 6; i++) run_xfer(i, vecs[i]);

    // Reset in the middle of an ACCESS phase of requester 3.
    do_reset();
    set_req(3, 1'b0, 8'h44, 32'h0);
    smp();
    chk("mr_ready3", 64'(req_ready), 64'(4'b1000));
    adv(); req_valid = '0;
    adv();
    smp();
    chk("mr_in_access", 64'(PENABLE), 64'(1));
    PRESET = 1'b1;
    #1;
    chk("mr_psel_async", 64'(PSEL), 64'(0));
    chk("mr_penable_async", 64'(PENABLE), 64'(0));
    adv(); adv();
    PRESET = 1'b0;
    set_req(0, 1'b1, 8'h10, 32'h0000_0010);
    set_req(3, 1'b1, 8'h13, 32'h0000_0013);
    PREADY = 1'b1;
    smp();
    chk("mr_ready0_first", 64'(req_ready), 64'(4'b0001));
    chk("mr_no_rsp", 64'(rsp_valid), 64'(0));
    adv(); req_valid[0] = 1'b0;
    smp(); chk("mr_no_rsp_c1", 64'(rsp_valid), 64'(0));
    adv(); adv();
    smp();
    chk("b2b_rsp0", 64'(rsp_valid), 64'(4'b0001));
    chk("b2b_ready3", 64'(req_ready), 64'(4'b1000));
    chk("b2b_busy", 64'(busy), 64'(1));
    adv(); req_valid[3] = 1'b0;
    adv(); adv();
    smp();
    chk("b2b_rsp3", 64'(rsp_valid), 64'(4'b1000));
    chk("b2b_paddr3", 64'(PADDR), 64'(8'h13));
    $display("reset-abort seq: req3 dropped, req0 then req3 served");
    adv();

    // All four requesters held valid: grants rotate 0,1,2,3,0,...
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(i * 4), 32'(i));
    PREADY = 1'b1;
    exp_next = 0; nrsp = 0;
    for (int c = 0; c < 60 && nrsp < 8; c++) begin
      smp();
      if (req_ready != '0) begin
        chk("rr_grant", 64'(req_ready), 64'(oh(exp_next)));
        q.push_back(exp_next);
        exp_next = (exp_next + 1) % NR;
      end
      if (rsp_valid != '0) begin
        if (q.size() > 0) chk("rr_rsp", 64'(rsp_valid), 64'(oh(q.pop_front())));
        chk("rr_busy", 64'(busy), 64'(1));
        $display("rr xfer %0d: rsp_valid %b", nrsp, rsp_valid);
        nrsp++;
      end
      adv();
    end
    chk("rr_count", 64'(nrsp), 64'(8));
    q.delete();

    // PREADY held low.
    do_reset();
    set_req(0, 1'b0, 8'h20, 32'h0);
    PRDATA = '1;
    smp();
    chk("stall_ready", 64'(req_ready), 64'(4'b0001));
    adv(); req_valid = '0;
    acc = 0; rsp_seen = 0; aborted = 0;
    for (int c = 1; c <= 200; c++) begin
      smp();
      if (PSEL && PENABLE) acc++;
`ifdef APB_ARB_TIMEOUT_EN
      if (acc > 0 && !PSEL) begin
        aborted = 1;
        chk("tmo_cycles", 64'(acc), 64'(TO));
        chk("tmo_rspv", 64'(rsp_valid), 64'(4'b0001));
        chk("tmo_err", 64'(rsp_err), 64'(1));
        chk("tmo_rdata", 64'(rsp_rdata), 64'(0));
        break;
      end
`else
      if (c == 100) begin
        chk("stall_psel", 64'(PSEL), 64'(1));
        chk("stall_penable", 64'(PENABLE), 64'(1));
        chk("stall_no_rsp", 64'(rsp_seen), 64'(0));
        break;
      end
`endif
      if (rsp_valid != '0) rsp_seen = 1;
      adv();
    end
`ifdef APB_ARB_TIMEOUT_EN
    chk("tmo_aborted", 64'(aborted), 64'(1));
    adv(); PREADY = 1'b1;
    smp(); chk("tmo_late_rspv", 64'(rsp_valid), 64'(0));
    adv(); PREADY = 1'b0;
    smp();
    chk("tmo_late_rspv2", 64'(rsp_valid), 64'(0));
    chk("tmo_late_psel", 64'(PSEL), 64'(0));
    $display("stall seq: timeout abort after %0d access cycles", acc);
`else
    adv(); PREADY = 1'b1;
    smp();
    adv(); PREADY = 1'b0;
    smp();
    chk("stall_release_rspv", 64'(rsp_valid), 64'(4'b0001));
    chk("stall_release_rdata", 64'(rsp_rdata), 64'(32'hFFFFFFFF));
    chk("stall_release_err", 64'(rsp_err), 64'(0));
    $display("stall seq: still in ACCESS after %0d cycles, completed on PREADY", acc);
`endif
    adv();

    // Randomized traffic against the reference model.
    do_reset();
    m_active = 0; m_resp_now = 0; m_age = 0; m_g = 0; m_rsp_g = 0; m_ptr = NR - 1;
    m_wr = 0; m_addr = '0; m_wdata = '0; m_exp_err = 0; m_exp_rdata = '0;
    acc_g = -1; n_rand = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (acc_g >= 0) req_valid[acc_g] = 1'b0;
      acc_g = -1;
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) set_req(i, 1'($urandom), 8'($urandom), $urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          req_addr[i*AW +: AW]  = 8'($urandom);
          req_wdata[i*DW +: DW] = $urandom;
        end else if ($urandom_range(0, 31) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      PREADY  = ($urandom_range(0, 2) != 0) || (m_active && m_age >= 8);
      PSLVERR = ($urandom_range(0, 7) == 0);
      PRDATA  = $urandom;
      smp();
      in_setup  = m_active && (m_age == 1);
      in_access = m_active && (m_age >= 2);
      g = rr_pick(m_ptr, req_valid);
      exp_ready = (!m_active && g >= 0) ? oh(g) : '0;
      chk("rnd_ready", 64'(req_ready), 64'(exp_ready));
      chk("rnd_psel", 64'(PSEL), 64'(in_setup || in_access));
      chk("rnd_penable", 64'(PENABLE), 64'(in_access));
      chk("rnd_rspv", 64'(rsp_valid), 64'(m_resp_now ? oh(m_rsp_g) : '0));
      chk("rnd_rdata", 64'(rsp_rdata), 64'(m_exp_rdata));
      chk("rnd_err", 64'(rsp_err), 64'(m_exp_err));
      chk("rnd_busy", 64'(busy), 64'(m_active || (m_resp_now && g >= 0)));
      if (m_active) begin
        chk("rnd_paddr", 64'(PADDR), 64'(m_addr));
        chk("rnd_pwrite", 64'(PWRITE), 64'(m_wr));
        chk("rnd_pwdata", 64'(PWDATA), 64'(m_wdata));
      end
      nresp = 0;
      if (in_access && PREADY) begin
        nresp       = 1;
        m_rsp_g     = m_g;
        m_exp_err   = PSLVERR;
        m_exp_rdata = m_wr ? '0 : PRDATA;
        m_active    = 0;
        n_rand++;
        $display("rand xfer %0d: req %0d %s addr 0x%02h err %0b rdata 0x%08h",
                 n_rand, m_g, m_wr ? "WR" : "RD", m_addr, m_exp_err, m_exp_rdata);
      end else if (m_active) begin
        m_age++;
      end
      m_resp_now = nresp;
      if (exp_ready != '0) begin
        m_active = 1;
        m_age    = 1;
        m_g      = g;
        m_ptr    = g;
        m_wr     = req_write[g];
        m_addr   = req_addr[g*AW +: AW];
        m_wdata  = req_wdata[g*DW +: DW];
        acc_g    = g;
      end
      adv();
    end
    chk("rnd_some_xfers", 64'(n_rand > 50), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
Name: apb_req_arbiter

Overview:
- Multi-requester APB master front end: shares one APB bus between NUM_REQ internal requesters (CPU bridge, DMA, debug) that target the register-file slave.
- Round-robin arbitration per transfer; generates legal SETUP/ACCESS sequencing, waits on PREADY, returns read data and error to the granted requester.
- Sits between requester logic and the APB slave, on the same PCLK domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_WIDTH, 8, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT_CYCLES, 16, max ACCESS-phase wait cycles (used only with the optional feature)

Ports:
PCLK  in  1  clock; one clock domain
PRESET  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester transfer request, held until accepted
req_ready  out  NUM_REQ  one-hot accept pulse
req_write  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
rsp_valid  out  NUM_REQ  one-hot completion pulse, 1 cycle
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  PSLVERR or timeout, valid with rsp_valid
busy  out  1  high while not IDLE
PSEL, PENABLE, PWRITE  out  1  APB control
PADDR  out  ADDR_WIDTH  APB address
PWDATA  out  DATA_WIDTH  APB write data
PRDATA  in  DATA_WIDTH  APB read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error

Behaviour:
- Reset (PRESET=1, asynchronous): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, busy all 0. RR pointer=NUM_REQ-1, so requester 0 has top priority first.
- FSM states are IDLE, SETUP and ACCESS.
- IDLE:
  - If any req_valid, grant g = first set bit searching from pointer+1, wrapping mod NUM_REQ.
  - req_ready[g]=1 combinationally in this cycle.
  - Latch write/addr/wdata of g and set pointer=g. Next state is SETUP.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from latched values. Next state is ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1; address, data and control held stable.
  - If PREADY=1: next cycle rsp_valid[g]=1 for one cycle, rsp_err=PSLVERR, rsp_rdata=PRDATA for reads and 0 for writes. PSEL and PENABLE drop to 0; next state is IDLE.
  - If PREADY=0: stay in ACCESS.
- All APB and rsp outputs are registered.
- Latency: accept at cycle 0, SETUP at cycle 1, ACCESS at cycle 2. With PREADY=1, rsp_valid at cycle 3, and the next grant is possible at cycle 3 (same cycle as rsp_valid).
- Minimum 3 cycles per transfer; throughput is one transfer per 3 cycles.
- rsp_rdata and rsp_err hold their last value when rsp_valid=0.
- Simultaneous requests: exactly one grant per IDLE cycle. An ungranted req_valid stays pending; no starvation (bounded by NUM_REQ transfers).
- A requester deasserting req_valid before acceptance is legal and ignored. Changing addr/data while pending is legal; values are sampled only at accept.
- Reset mid-transfer: transfer dropped, no rsp_valid, PSEL drops immediately (asynchronous).
- busy=1 in SETUP and ACCESS, and in the rsp_valid cycle only if a new grant occurred.

Optional Feature:
- Macro APB_ARB_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES, the transfer aborts: PSEL/PENABLE to 0, rsp_valid[g]=1 next cycle, rsp_err=1, rsp_rdata=0, then IDLE. A late PREADY after abort is ignored.
- Undefined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- Reset, then req 0 writes 0xDEADBEEF to 0x08 with PREADY=1 -> req_ready[0] at c0; c1 PSEL=1 PENABLE=0 PADDR=0x08; c2 PENABLE=1; c3 rsp_valid=4'b0001, rsp_err=0.
- Req 2 reads 0x08 with PRDATA=0xDEADBEEF and PREADY low for 3 cycles -> ACCESS lasts 4 cycles, signals stable; rsp_valid[2]=1, rsp_rdata=0xDEADBEEF.
- req_valid=4'b1111 held continuously -> grants in order 0,1,2,3,0; each requester gets exactly one rsp_valid per 4 transfers.
- PSLVERR=1 with PREADY on a write by req 1 -> rsp_valid[1]=1, rsp_err=1, rsp_rdata=0.
- PRESET asserted during ACCESS of req 3 -> PSEL=0 immediately, no rsp_valid; after release, req 0 is granted before req 3 when both are valid.
- APB_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and PREADY tied 0 -> after 16 ACCESS cycles, PSEL drops and rsp_err=1, rsp_rdata=0. Without the macro, still in ACCESS at cycle 100.
